maria_regfile_p: RTL and testbench
==================================

# maria_regfile_p

Parametrised MARIA register file: decodes CPU accesses in the MARIA register window, holds background, palette, control, character-base and display-list-list pointer registers, and drives them to the MARIA line/DMA engines. Successor to the fixed 25-entry map: palette count is a parameter, and optional line-synchronous palette write deferral uses shadow registers committed at line end. Sits between the CPU bus decode and the MARIA video/DMA logic.

## Interface
- NUM_PAL, 8: palette count; legal values 8 or 16.
- DEFER_PAL, 1: 1 = palette/background writes during active line are staged and committed at `line_end`; 0 = immediate.
- BAD_READ, 8'hBE: value returned for reads of unmapped/write-only offsets.
- sysclock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- bus_ce  in  1  one-cycle CPU bus phase strobe; accesses are sampled only when high.
- sel  in  1  MARIA chip select from the system decoder.
- we  in  1  1 = write, 0 = read (qualified by `bus_ce & sel`).
- addr  in  $clog2(4*NUM_PAL)  byte offset within the MARIA window.
- wdata  in  8  write data.
- rdata  out  8  registered read data.
- status_in  in  8  live status byte, returned at offset 0x08.
- line_active  in  1  high while MARIA renders the visible portion of a line.
- line_end  in  1  one-cycle pulse at end of each line.
- color_map  out  8*(1+3*NUM_PAL)  live colours; byte 0 = background, byte 1+3p+c = palette p colour c.
- ctrl  out  8  control register.
- char_base  out  8  CHARBASE.
- zp  out  16  {DPPH, DPPL}.
- zp_valid  out  1  sticky: both DPPH and DPPL written since reset.
- wsync_pulse  out  1  one-cycle pulse on WSYNC write.
- pending  out  1  OR of all shadow pending bits.

## Operation
- Access fires on a cycle with `bus_ce & sel`; otherwise no register changes and `rdata` holds.
- Offset map: offset 0 = background; offset 4p+1+c (c=0..2) = palette p colour c. Offsets 4p for p=1..7: 0x04 WSYNC (write-only), 0x08 STATUS (read-only), 0x0C DPPH, 0x10 DPPL, 0x14 CHARBASE, 0x18 unused, 0x1C CTRL. For NUM_PAL=16, offsets 4p with p=8..15 are unused.
- Unused offsets: writes ignored; reads return BAD_READ. WSYNC reads return BAD_READ; STATUS writes ignored.
- WSYNC write: `wsync_pulse` high the following cycle for exactly one cycle; data discarded.
- DPPH/DPPL writes set per-byte written flags; `zp_valid` = AND of flags, cleared only by reset.
- Colour entries (background + palettes): each has live and shadow byte plus pending bit (shadow/pending exist only if DEFER_PAL=1).
  - DEFER_PAL=0, or `line_active`=0: write goes to live, pending cleared.
  - DEFER_PAL=1 and `line_active`=1: write goes to shadow, pending set; repeat writes overwrite shadow.
  - `line_end`: every pending entry copies shadow to live, pending cleared.
  - Write and `line_end` in same cycle to same entry: written value goes to live, pending cleared (write wins). Other pending entries commit normally.
- Colour readback returns shadow if pending, else live (CPU reads what it last wrote).

## Timing
- Reset values: color_map all 0, shadows 0, pending bits 0, ctrl 8'h40, char_base 8'h00, zp 16'h1820, zp_valid 0, wsync_pulse 0, pending 0, rdata 8'h00.
- Write latency: target register updates on the edge where the access fires; visible on outputs next cycle.
- Read latency: `rdata` valid one cycle after access fires; holds until next read access. STATUS captures `status_in` at the access edge.
- Commit latency: live colour updates on the `line_end` edge.
- Reset mid-line discards all pending shadow writes.

## Test plan
- Reset, no access -> ctrl=8'h40, zp=16'h1820, zp_valid=0, color_map=0, rdata=8'h00.
- DEFER_PAL=0: write 8'h55 to offset 0x06 (pal1 c1), read back -> color_map byte 5=8'h55 next cycle, rdata=8'h55 one cycle after read.
- DEFER_PAL=1, line_active=1: write 8'h9A to offset 0x01 -> live byte 1 stays 0, pending=1, readback 8'h9A; pulse line_end -> live byte 1=8'h9A, pending=0.
- Same-cycle write 8'h11 to 0x02 with line_end while 0x01 pending 8'h22 -> byte 2=8'h11 and byte 1=8'h22 live, pending=0.
- Write DPPH 8'h30 then DPPL 8'h00 -> zp=16'h3000, zp_valid rises after second write only; write 0x04 -> single-cycle wsync_pulse.
- Read 0x18, 0x04 -> 8'hBE; NUM_PAL=16 write offset 0x3D -> palette 15 c0 updated; write 0x20 ignored.

Source files
------------

// File: rtl/maria_regfile_p_if.sv
// CPU-side access bus for the MARIA register window.
// The CPU decoder drives the master side and the register file is the slave.
interface maria_regfile_p_if #(
  parameter int unsigned NUM_PAL = 8
);
  localparam int unsigned AddrW = $clog2(4 * NUM_PAL);

  logic             bus_ce;
  logic             sel;
  logic             we;
  logic [AddrW-1:0] addr;
  logic [7:0]       wdata;
  logic [7:0]       rdata;

  modport master (
    output bus_ce,
    output sel,
    output we,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  bus_ce,
    input  sel,
    input  we,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/maria_regfile_p.sv
// MARIA register file: colour, control, charbase and display-list-list pointer
// registers, with optional line-synchronous deferral of colour writes.
module maria_regfile_p #(
  parameter int unsigned NUM_PAL   = 8,
  parameter int unsigned DEFER_PAL = 1,
  parameter logic [7:0]  BAD_READ  = 8'hBE
) (
  input  logic                         sysclock_i,
  input  logic                         reset_i,
  maria_regfile_p_if.slave             bus,
  input  logic [7:0]                   status_i,
  input  logic                         line_active_i,
  input  logic                         line_end_i,
  output logic [8*(1+3*NUM_PAL)-1:0]   color_map_o,
  output logic [7:0]                   ctrl_o,
  output logic [7:0]                   char_base_o,
  output logic [15:0]                  zp_o,
  output logic                         zp_valid_o,
  output logic                         wsync_pulse_o,
  output logic                         pending_o
);

  localparam int unsigned NumColor = 1 + 3 * NUM_PAL;
  localparam int unsigned AddrW    = $clog2(4 * NUM_PAL);
  localparam int unsigned RowW     = AddrW - 2;
  localparam int unsigned IdxW     = $clog2(NumColor);
  localparam bit          DeferOn  = (DEFER_PAL != 0);

  logic [NumColor-1:0][7:0] live_q, live_d;
  logic [NumColor-1:0][7:0] shadow_q, shadow_d;
  logic [NumColor-1:0]      pend_q, pend_d;
  logic [7:0]               ctrl_q, ctrl_d;
  logic [7:0]               char_base_q, char_base_d;
  logic [7:0]               dpph_q, dpph_d;
  logic [7:0]               dppl_q, dppl_d;
  logic                     dpph_wr_q, dpph_wr_d;
  logic                     dppl_wr_q, dppl_wr_d;
  logic                     wsync_q, wsync_d;
  logic [7:0]               rdata_q, rdata_d;

  logic             access, wr_en, rd_en;
  logic [AddrW-1:0] off;
  logic [RowW-1:0]  row;
  logic [1:0]       col;
  logic             is_color;
  logic [IdxW-1:0]  color_idx;
  logic             is_wsync, is_status, is_dpph, is_dppl, is_charbase, is_ctrl;
  logic [7:0]       rd_val;

  assign access = bus.bus_ce & bus.sel;
  assign wr_en  = access & bus.we;
  assign rd_en  = access & ~bus.we;
  assign off    = bus.addr;
  assign row    = off[AddrW-1:2];
  assign col    = off[1:0];

  // Offset 0 is background; any non-zero column is a palette colour.
  always_comb begin
    is_color    = (off == '0) || (col != 2'd0);
    color_idx   = '0;
    is_wsync    = 1'b0;
    is_status   = 1'b0;
    is_dpph     = 1'b0;
    is_dppl     = 1'b0;
    is_charbase = 1'b0;
    is_ctrl     = 1'b0;
    if (off != '0 && col != 2'd0) begin
      color_idx = IdxW'(32'd3 * 32'(row) + 32'(col));
    end
    if (!is_color) begin
      case (32'(row))
        32'd1:   is_wsync    = 1'b1;
        32'd2:   is_status   = 1'b1;
        32'd3:   is_dpph     = 1'b1;
        32'd4:   is_dppl     = 1'b1;
        32'd5:   is_charbase = 1'b1;
        32'd7:   is_ctrl     = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_val = BAD_READ;
    if (is_color) begin
      rd_val = pend_q[color_idx] ? shadow_q[color_idx] : live_q[color_idx];
    end else if (is_status) begin
      rd_val = status_i;
    end else if (is_dpph) begin
      rd_val = dpph_q;
    end else if (is_dppl) begin
      rd_val = dppl_q;
    end else if (is_charbase) begin
      rd_val = char_base_q;
    end else if (is_ctrl) begin
      rd_val = ctrl_q;
    end
  end

  // A write in the line_end cycle bypasses the shadow so the CPU value wins.
  always_comb begin
    live_d   = live_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    for (int i = 0; i < NumColor; i++) begin
      if (wr_en && is_color && color_idx == IdxW'(i)) begin
        if (DeferOn && line_active_i && !line_end_i) begin
          shadow_d[i] = bus.wdata;
          pend_d[i]   = 1'b1;
        end else begin
          live_d[i] = bus.wdata;
          pend_d[i] = 1'b0;
        end
      end else if (DeferOn && line_end_i && pend_q[i]) begin
        live_d[i] = shadow_q[i];
        pend_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    ctrl_d      = ctrl_q;
    char_base_d = char_base_q;
    dpph_d      = dpph_q;
    dppl_d      = dppl_q;
    dpph_wr_d   = dpph_wr_q;
    dppl_wr_d   = dppl_wr_q;
    wsync_d     = wr_en & is_wsync;
    rdata_d     = rd_en ? rd_val : rdata_q;
    if (wr_en) begin
      if (is_ctrl)     ctrl_d      = bus.wdata;
      if (is_charbase) char_base_d = bus.wdata;
      if (is_dpph) begin
        dpph_d    = bus.wdata;
        dpph_wr_d = 1'b1;
      end
      if (is_dppl) begin
        dppl_d    = bus.wdata;
        dppl_wr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sysclock_i or posedge reset_i) begin
    if (reset_i) begin
      live_q      <= '0;
      shadow_q    <= '0;
      pend_q      <= '0;
      ctrl_q      <= 8'h40;
      char_base_q <= 8'h00;
      dpph_q      <= 8'h18;
      dppl_q      <= 8'h20;
      dpph_wr_q   <= 1'b0;
      dppl_wr_q   <= 1'b0;
      wsync_q     <= 1'b0;
      rdata_q     <= 8'h00;
    end else begin
      live_q      <= live_d;
      shadow_q    <= shadow_d;
      pend_q      <= pend_d;
      ctrl_q      <= ctrl_d;
      char_base_q <= char_base_d;
      dpph_q      <= dpph_d;
      dppl_q      <= dppl_d;
      dpph_wr_q   <= dpph_wr_d;
      dppl_wr_q   <= dppl_wr_d;
      wsync_q     <= wsync_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.rdata     = rdata_q;
  assign color_map_o   = live_q;
  assign ctrl_o        = ctrl_q;
  assign char_base_o   = char_base_q;
  assign zp_o          = {dpph_q, dppl_q};
  assign zp_valid_o    = dpph_wr_q & dppl_wr_q;
  assign wsync_pulse_o = wsync_q;
  assign pending_o     = |pend_q;

endmodule

// File: tb/tb_maria_regfile_p.sv
// Bench for maria_regfile_p: a deferred 8-palette instance and an immediate
// 16-palette instance; read data is checked by per-instance monitors.
module tb_maria_regfile_p;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  exp_t q8[$];
  exp_t q16[$];

  // Instance A: 8 palettes, deferred colour writes
  maria_regfile_p_if #(.NUM_PAL(8)) b8 ();
  logic [7:0]   status8 = 8'h00;
  logic         la8 = 1'b0, le8 = 1'b0;
  logic [199:0] cmap8;
  logic [7:0]   ctrl8, cbase8;
  logic [15:0]  zp8;
  logic         zpv8, ws8, pend8;

  maria_regfile_p #(.NUM_PAL(8), .DEFER_PAL(1), .BAD_READ(8'hBE)) u_dut8 (
    .sysclock_i    (clk),
    .reset_i       (rst),
    .bus           (b8),
    .status_i      (status8),
    .line_active_i (la8),
    .line_end_i    (le8),
    .color_map_o   (cmap8),
    .ctrl_o        (ctrl8),
    .char_base_o   (cbase8),
    .zp_o          (zp8),
    .zp_valid_o    (zpv8),
    .wsync_pulse_o (ws8),
    .pending_o     (pend8)
  );

  // Instance B: 16 palettes, immediate colour writes
  maria_regfile_p_if #(.NUM_PAL(16)) b16 ();
  logic         la16 = 1'b0, le16 = 1'b0;
  logic [391:0] cmap16;
  logic [7:0]   ctrl16, cbase16;
  logic [15:0]  zp16;
  logic         zpv16, ws16, pend16;

  maria_regfile_p #(.NUM_PAL(16), .DEFER_PAL(0), .BAD_READ(8'hBE)) u_dut16 (
    .sysclock_i    (clk),
    .reset_i       (rst),
    .bus           (b16),
    .status_i      (8'h00),
    .line_active_i (la16),
    .line_end_i    (le16),
    .color_map_o   (cmap16),
    .ctrl_o        (ctrl16),
    .char_base_o   (cbase16),
    .zp_o          (zp16),
    .zp_valid_o    (zpv16),
    .wsync_pulse_o (ws16),
    .pending_o     (pend16)
  );

  task automatic check(input string name, input logic [391:0] act, input logic [391:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr8(input logic [4:0] a, input logic [7:0] d);
    b8.bus_ce = 1'b1; b8.sel = 1'b1; b8.we = 1'b1; b8.addr = a; b8.wdata = d;
    cyc();
    b8.bus_ce = 1'b0; b8.sel = 1'b0; b8.we = 1'b0;
  endtask

  task automatic rd8(input logic [4:0] a, input logic [7:0] e, input string name);
    q8.push_back('{name: name, val: e});
    b8.bus_ce = 1'b1; b8.sel = 1'b1; b8.we = 1'b0; b8.addr = a;
    cyc();
    b8.bus_ce = 1'b0; b8.sel = 1'b0;
  endtask

  task automatic wr16(input logic [5:0] a, input logic [7:0] d);
    b16.bus_ce = 1'b1; b16.sel = 1'b1; b16.we = 1'b1; b16.addr = a; b16.wdata = d;
    cyc();
    b16.bus_ce = 1'b0; b16.sel = 1'b0; b16.we = 1'b0;
  endtask

  task automatic rd16(input logic [5:0] a, input logic [7:0] e, input string name);
    q16.push_back('{name: name, val: e});
    b16.bus_ce = 1'b1; b16.sel = 1'b1; b16.we = 1'b0; b16.addr = a;
    cyc();
    b16.bus_ce = 1'b0; b16.sel = 1'b0;
  endtask

  // Monitors: a read fires at an edge, rdata is compared just after that edge.
  always @(posedge clk) begin : mon8
    logic fire;
    exp_t e;
    fire = b8.bus_ce & b8.sel & ~b8.we;
    if (fire) begin
      #1;
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL mon8 unexpected read: got %0h expected none", b8.rdata);
      end else begin
        e = q8.pop_front();
        check(e.name, 392'(b8.rdata), 392'(e.val));
      end
    end
  end

  always @(posedge clk) begin : mon16
    logic fire;
    exp_t e;
    fire = b16.bus_ce & b16.sel & ~b16.we;
    if (fire) begin
      #1;
      if (q16.size() == 0) begin
        total++; bad++;
        $display("FAIL mon16 unexpected read: got %0h expected none", b16.rdata);
      end else begin
        e = q16.pop_front();
        check(e.name, 392'(b16.rdata), 392'(e.val));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [199:0] e8;
    logic [391:0] e16;
    e8  = '0;
    e16 = '0;
    b8.bus_ce = 1'b0; b8.sel = 1'b0; b8.we = 1'b0; b8.addr = '0; b8.wdata = '0;
    b16.bus_ce = 1'b0; b16.sel = 1'b0; b16.we = 1'b0; b16.addr = '0; b16.wdata = '0;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    check("rst ctrl", 392'(ctrl8), 392'(8'h40));
    check("rst zp", 392'(zp8), 392'(16'h1820));
    check("rst zp_valid", 392'(zpv8), 392'(1'b0));
    check("rst cmap8", 392'(cmap8), 392'(e8));
    check("rst rdata", 392'(b8.rdata), 392'(8'h00));
    check("rst pending", 392'(pend8), 392'(1'b0));
    check("rst cmap16", cmap16, e16);

    // Deferred write during active line
    la8 = 1'b1;
    wr8(5'h01, 8'h9A);
    check("defer live unchanged", 392'(cmap8), 392'(e8));
    check("defer pending set", 392'(pend8), 392'(1'b1));
    rd8(5'h01, 8'h9A, "defer readback shadow");
    le8 = 1'b1;
    cyc();
    le8 = 1'b0;
    e8[8 +: 8] = 8'h9A;
    check("line_end commit", 392'(cmap8), 392'(e8));
    check("line_end pending clr", 392'(pend8), 392'(1'b0));

    // Same-cycle write and line_end
    wr8(5'h01, 8'h22);
    check("pending before collide", 392'(pend8), 392'(1'b1));
    le8 = 1'b1;
    wr8(5'h02, 8'h11);
    le8 = 1'b0;
    e8[8 +: 8]  = 8'h22;
    e8[16 +: 8] = 8'h11;
    check("collide cmap", 392'(cmap8), 392'(e8));
    check("collide pending", 392'(pend8), 392'(1'b0));

    // Outside active line writes go live
    la8 = 1'b0;
    wr8(5'h00, 8'h5A);
    e8[0 +: 8] = 8'h5A;
    check("bg immediate", 392'(cmap8), 392'(e8));

    // Display-list-list pointer
    wr8(5'h0C, 8'h30);
    check("zp after dpph", 392'(zp8), 392'(16'h3020));
    check("zp_valid after dpph", 392'(zpv8), 392'(1'b0));
    wr8(5'h10, 8'h00);
    check("zp after dppl", 392'(zp8), 392'(16'h3000));
    check("zp_valid after dppl", 392'(zpv8), 392'(1'b1));

    // WSYNC pulse
    check("wsync idle", 392'(ws8), 392'(1'b0));
    wr8(5'h04, 8'hFF);
    check("wsync pulse", 392'(ws8), 392'(1'b1));
    cyc();
    check("wsync one cycle", 392'(ws8), 392'(1'b0));

    // Reads of unmapped / write-only / status
    rd8(5'h18, 8'hBE, "read unused 0x18");
    rd8(5'h04, 8'hBE, "read wsync");
    status8 = 8'h3C;
    rd8(5'h08, 8'h3C, "read status");
    status8 = 8'h00;
    wr8(5'h08, 8'h77);
    cyc();
    check("rdata holds", 392'(b8.rdata), 392'(8'h3C));
    rd8(5'h08, 8'h00, "status write ignored");

    // Control and charbase
    wr8(5'h1C, 8'h5F);
    check("ctrl write", 392'(ctrl8), 392'(8'h5F));
    wr8(5'h14, 8'hA0);
    check("charbase write", 392'(cbase8), 392'(8'hA0));
    b8.bus_ce = 1'b1; b8.sel = 1'b0; b8.we = 1'b1; b8.addr = 5'h1C; b8.wdata = 8'h00;
    cyc();
    b8.bus_ce = 1'b0; b8.we = 1'b0;
    check("no sel no write", 392'(ctrl8), 392'(8'h5F));

    // 16-palette immediate instance
    la16 = 1'b1;
    wr16(6'h06, 8'h55);
    e16[40 +: 8] = 8'h55;
    check("imm pal1 c1", cmap16, e16);
    rd16(6'h06, 8'h55, "imm readback");
    wr16(6'h3D, 8'hC3);
    e16[368 +: 8] = 8'hC3;
    check("pal15 c0", cmap16, e16);
    wr16(6'h20, 8'h99);
    check("unused 0x20 ignored", cmap16, e16);
    rd16(6'h20, 8'hBE, "read unused 0x20");
    check("imm pending", 392'(pend16), 392'(1'b0));

    // Reset mid-line discards shadows
    la8 = 1'b1;
    wr8(5'h03, 8'h77);
    check("pending before reset", 392'(pend8), 392'(1'b1));
    rst = 1'b1;
    #2;
    check("reset clears pending", 392'(pend8), 392'(1'b0));
    check("reset clears cmap", 392'(cmap8), 392'(0));
    check("reset clears zp_valid", 392'(zpv8), 392'(1'b0));
    cyc();
    rst = 1'b0;
    la8 = 1'b0;
    cyc();
    le8 = 1'b1;
    cyc();
    le8 = 1'b0;
    check("no commit after reset", 392'(cmap8), 392'(0));

    repeat (3) cyc();
    check("q8 drained", 392'(q8.size()), 392'(0));
    check("q16 drained", 392'(q16.size()), 392'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
